// File: rtl/reg_writeback.sv
// Writeback queue: merges load and ALU results in program order into the single
// register-file write port. Optional operand forwarding is built when WB_FORWARD_EN is defined.
module reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       in_ready,
    output logic                       REG_WRITE,
    output logic [4:0]                 write_reg,
    output logic [DATA_W-1:0]          writeData,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow,
    input  logic [4:0]                 fwd_reg1,
    input  logic [4:0]                 fwd_reg2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [DATA_W-1:0]          fwd_data1,
    output logic [DATA_W-1:0]          fwd_data2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [4:0]        r_q_rd   [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [PW-1:0]     r_head, r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ovf;

    logic [CW-1:0] w_free, w_npush;
    logic          w_mem_offer, w_alu_offer, w_mem_push, w_alu_push, w_drop, w_pop;
    logic [PW-1:0] w_alu_slot;

    // Capacity uses the pre-pop count, so a same-edge dequeue never frees a slot early.
    assign w_free      = CW'(DEPTH) - r_count;
    assign w_mem_offer = mem_valid && (mem_rd != 5'd31);
    assign w_alu_offer = alu_valid && (alu_rd != 5'd31);
    assign w_mem_push  = w_mem_offer && (w_free >= CW'(1));
    assign w_alu_push  = w_alu_offer && (w_free >= (w_mem_push ? CW'(2) : CW'(1)));
    assign w_drop      = (w_mem_offer && !w_mem_push) || (w_alu_offer && !w_alu_push);
    assign w_pop       = (r_count != '0);
    assign w_npush     = CW'(w_mem_push) + CW'(w_alu_push);
    assign w_alu_slot  = w_mem_push ? r_tail + PW'(1) : r_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_rd[i]   <= '0;
                r_q_data[i] <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            REG_WRITE <= 1'b0;
            write_reg <= '0;
            writeData <= '0;
        end else begin
            if (w_mem_push) begin
                r_q_rd[r_tail]   <= mem_rd;
                r_q_data[r_tail] <= mem_data;
            end
            if (w_alu_push) begin
                r_q_rd[w_alu_slot]   <= alu_rd;
                r_q_data[w_alu_slot] <= alu_data;
            end
            r_tail  <= r_tail + PW'(w_npush);
            r_count <= r_count + w_npush - CW'(w_pop);
            if (w_drop)
                r_ovf <= 1'b1;
            REG_WRITE <= w_pop;
            if (w_pop) begin
                write_reg <= r_q_rd[r_head];
                writeData <= r_q_data[r_head];
                r_head    <= r_head + PW'(1);
            end
        end
    end

    assign in_ready = (w_free >= CW'(2));
    assign pending  = r_count;
    assign overflow = r_ovf;

    logic [1:0]             w_hit;
    logic [1:0][DATA_W-1:0] w_fdata;

`ifdef WB_FORWARD_EN
    logic [1:0][4:0] w_freg;
    logic [PW-1:0]   w_idx;
    assign w_freg = {fwd_reg2, fwd_reg1};

    // Scan oldest to youngest (output register, then head..tail) so the last match wins.
    always_comb begin
        w_hit   = '0;
        w_fdata = '0;
        w_idx   = '0;
        for (int p = 0; p < 2; p++) begin
            if (w_freg[p] != 5'd31) begin
                if (REG_WRITE && (write_reg == w_freg[p])) begin
                    w_hit[p]   = 1'b1;
                    w_fdata[p] = writeData;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    w_idx = r_head + PW'(i);
                    if ((CW'(i) < r_count) && (r_q_rd[w_idx] == w_freg[p])) begin
                        w_hit[p]   = 1'b1;
                        w_fdata[p] = r_q_data[w_idx];
                    end
                end
            end
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_reg1, fwd_reg2};
    assign w_hit        = '0;
    assign w_fdata      = '0;
`endif

    assign fwd_hit1  = w_hit[0];
    assign fwd_hit2  = w_hit[1];
    assign fwd_data1 = w_fdata[0];
    assign fwd_data2 = w_fdata[1];
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage that collects completed results from the ALU path and the data-memory load path, queues them in program order, and drives the single write port of the 32 x 64-bit LEGv8 register file (REG_WRITE / write_reg / writeData). It decouples producers that finish in the same cycle from the one-write-per-cycle register file. It also optionally forwards not-yet-written results to the operand read stage.

## Interface
- DEPTH, 4, pending-write queue entries (power of two, >= 2)
- DATA_W, 64, result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- alu_valid  in  1  ALU result available this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result available this cycle
- mem_rd  in  5  load destination register
- mem_data  in  DATA_W  loaded data
- in_ready  out  1  queue can accept two entries this cycle
- REG_WRITE  out  1  register file write enable, registered
- write_reg  out  5  register file write address, registered
- writeData  out  DATA_W  register file write data, registered
- pending  out  $clog2(DEPTH+1)  valid queue entries
- overflow  out  1  sticky: an offered result was dropped
- fwd_reg1, fwd_reg2  in  5  operand registers being read
- fwd_hit1, fwd_hit2  out  1  newer value pending for that operand
- fwd_data1, fwd_data2  out  DATA_W  forwarded value

## Operation
- Circular queue: head/tail pointers, log2(DEPTH) bits, wrap modulo DEPTH; count tracked separately.
- Enqueue, each edge: if mem_valid, push {mem_rd, mem_data}, then if alu_valid, push {alu_rd, alu_data}. The load is older, so it goes first when both are valid.
- A result with rd == 31 (XZR) is discarded at enqueue. It is never queued and never counted.
- in_ready = (DEPTH - count) >= 2. It depends on count only, not on a same-cycle dequeue.
- Producers assert valid only while in_ready is 1.
  - If valid arrives while in_ready is 0, each offered entry that does not fit is dropped and overflow is set.
  - Entries that fit are still accepted.
  - overflow clears only on rst.
- Dequeue, each edge: if count > 0, load the head into the output registers with REG_WRITE = 1, then advance head. Otherwise REG_WRITE = 0, and write_reg/writeData hold their previous values.
- Enqueue and dequeue in the same edge are both performed: count += pushes - pop.
- Forwarding lookup (combinational) searches the queue entries plus the output register while REG_WRITE = 1.
  - The youngest match wins.
  - fwd_regN == 31 never hits.
  - On a miss, fwd_dataN = 0.

## Timing
- Reset values: REG_WRITE 0, write_reg 0, writeData 0, pending 0, overflow 0, in_ready 1, fwd_hit* 0. Queue is emptied and pointers are zeroed.
- Latency: a result sampled at edge N (empty queue) is presented with REG_WRITE = 1 in the cycle after edge N+1.
- Throughput: one register-file write per cycle; REG_WRITE is a one-cycle pulse per entry.
- Ordering: writes leave in acceptance order. Two writes to the same register both reach the register file, and the later one is final.
- rst mid-operation discards all pending entries. No write is issued in the cycle after the reset edge.
- Full queue with a simultaneous pop: in_ready still reflects the pre-pop count. There is no same-cycle reuse of the freed slot.

## Configuration
- WB_FORWARD_EN defined: forwarding search logic is built, and fwd_hit*/fwd_data* behave as above.
- Undefined:
  - Search logic is omitted.
  - fwd_hit1/fwd_hit2 are tied 0 and fwd_data1/fwd_data2 are tied 0.
  - The port list is unchanged; fwd_reg* are ignored.
  - Queue/write behaviour is identical.

## Test plan
- Reset, then alu_valid with rd = 5, data = 0xAA for one cycle -> REG_WRITE = 1, write_reg = 5, writeData = 0xAA exactly once, two edges later; pending returns to 0.
- Same cycle mem (rd = 3, 0x11) and alu (rd = 4, 0x22) -> consecutive writes X3 = 0x11 then X4 = 0x22; pending peaks at 2.
- alu_valid with rd = 31, data = 0xFF -> no REG_WRITE pulse, pending stays 0, overflow stays 0.
- Both valids held high every cycle with DEPTH = 4:
  - in_ready falls once count >= 3.
  - Offering while in_ready = 0 with a full queue sets overflow = 1, the dropped data never appears on writeData, and overflow stays 1 until rst.
- WB_FORWARD_EN defined: queue X7 = 1, then X7 = 2; fwd_reg1 = 7 -> fwd_hit1 = 1, fwd_data1 = 2; fwd_reg2 = 31 -> fwd_hit2 = 0. Without the macro, both hits are 0.
- Three entries pending, assert rst for one edge -> next cycle REG_WRITE = 0, pending = 0; no stale write is ever issued afterward.
